breakout_pixel_gen: RTL

- Downstream consumer of the 800x600 VGA sync stage. Takes pixel_x, pixel_y, video_on and p_tick, and produces the registered 12-bit RGB stream for the Breakout playfield.
- Owns the per-frame game objects: left/right/top walls, button-driven paddle, and a bouncing ball with serve/miss/lives control.
- Brick rendering is out of scope; a later stage composes bricks over this output.

---
 rtl/breakout_pixel_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/breakout_pixel_gen.sv
// Breakout playfield pixel generator: walls, paddle and bouncing ball.
// Objects advance once per frame; the RGB output is registered every clk.
module breakout_pixel_gen #(
   parameter int SCREEN_W  = 800,
   parameter int SCREEN_H  = 600,
   parameter int WALL_W    = 16,
   parameter int PADDLE_Y  = 560,
   parameter int PADDLE_H  = 8,
   parameter int PADDLE_W  = 96,
   parameter int PADDLE_V  = 8,
   parameter int BALL_SIZE = 8,
   parameter int BALL_V    = 2,
   parameter int LIVES     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        video_on,
   input  logic [10:0] pixel_x,
   input  logic [10:0] pixel_y,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        serve,
   output logic [11:0] rgb,
   output logic        miss,
   output logic [1:0]  lives,
   output logic        game_over
);

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   localparam logic [11:0] C_WALL  = 12'(WALL_W);
   localparam logic [11:0] C_RWALL = 12'(SCREEN_W - WALL_W);
   localparam logic [11:0] C_RLIM  = 12'(SCREEN_W - WALL_W - 1);
   localparam logic [11:0] C_PV    = 12'(PADDLE_V);
   localparam logic [11:0] C_PMAX  = 12'(SCREEN_W - WALL_W - PADDLE_W);
   localparam logic [11:0] C_PY    = 12'(PADDLE_Y);
   localparam logic [11:0] C_PYB   = 12'(PADDLE_Y + PADDLE_H - 1);
   localparam logic [11:0] C_PW1   = 12'(PADDLE_W - 1);
   localparam logic [11:0] C_BS1   = 12'(BALL_SIZE - 1);
   localparam logic [11:0] C_POFF  = 12'(PADDLE_W/2 - BALL_SIZE/2);
   localparam logic [11:0] C_SH    = 12'(SCREEN_H);
   localparam logic [10:0] C_PRST  = 11'((SCREEN_W - PADDLE_W)/2);
   localparam logic [10:0] C_BXRST = 11'((SCREEN_W - PADDLE_W)/2 + PADDLE_W/2 - BALL_SIZE/2);
   localparam logic [10:0] C_PARKY = 11'(PADDLE_Y - BALL_SIZE);
   localparam logic [3:0]  C_VP    = 4'(BALL_V);
   localparam logic [3:0]  C_VN    = 4'(-BALL_V);
   localparam logic [1:0]  C_LIVES = 2'(LIVES);

   state_t      state_q;
   logic [10:0] paddle_q, paddle_d;
   logic [10:0] ball_x_q, ball_x_d;
   logic [10:0] ball_y_q, ball_y_d;
   logic [10:0] park_x_d;
   logic [3:0]  dx_q, dx_d;
   logic [3:0]  dy_q, dy_d;
   logic [1:0]  lives_q;
   logic        miss_q;
   logic        over_q;
   logic [11:0] rgb_q, rgb_d;
   logic        frame_tick;
   logic        hit;
   logic [11:0] px, py, bx, by, pd;

   assign px = {1'b0, pixel_x};
   assign py = {1'b0, pixel_y};
   assign bx = {1'b0, ball_x_q};
   assign by = {1'b0, ball_y_q};
   assign pd = {1'b0, paddle_q};

   assign frame_tick = p_tick && (pixel_x == 11'd0) && (pixel_y == 11'(SCREEN_H));

   // Per-frame object motion: paddle clamp, wall/paddle reflection, new position
   always_comb begin
      paddle_d = paddle_q;
      if (btn_left && !btn_right)
         paddle_d = (pd >= C_WALL + C_PV) ? 11'(pd - C_PV) : 11'(C_WALL);
      else if (btn_right && !btn_left)
         paddle_d = (pd + C_PV <= C_PMAX) ? 11'(pd + C_PV) : 11'(C_PMAX);
      park_x_d = 11'({1'b0, paddle_d} + C_POFF);
      hit = !dy_q[3] && (dy_q != 4'd0)
         && (by + C_BS1 >= C_PY) && (by + C_BS1 <= C_PYB)
         && (bx + C_BS1 >= pd) && (bx <= pd + C_PW1);
      dx_d = dx_q;
      if (bx <= C_WALL)
         dx_d = C_VP;
      else if (bx + C_BS1 >= C_RLIM)
         dx_d = C_VN;
      dy_d = dy_q;
      if (by <= C_WALL)
         dy_d = C_VP;
      if (hit)
         dy_d = C_VN;
      ball_x_d = 11'(bx + {{8{dx_d[3]}}, dx_d});
      ball_y_d = 11'(by + {{8{dy_d[3]}}, dy_d});
   end

   // Pixel colour by priority: ball, paddle, wall, background
   always_comb begin
      rgb_d = 12'h000;
      if (video_on) begin
         if (state_q != OVER && px >= bx && px <= bx + C_BS1
             && py >= by && py <= by + C_BS1)
            rgb_d = 12'hFFF;
         else if (py >= C_PY && py <= C_PYB && px >= pd && px <= pd + C_PW1)
            rgb_d = 12'h0F0;
         else if (px < C_WALL || px >= C_RWALL || py < C_WALL)
            rgb_d = 12'h888;
      end
   end

   // Game state machine, object registers and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         paddle_q <= C_PRST;
         ball_x_q <= C_BXRST;
         ball_y_q <= C_PARKY;
         dx_q     <= C_VP;
         dy_q     <= C_VN;
         lives_q  <= C_LIVES;
         miss_q   <= 1'b0;
         over_q   <= 1'b0;
         rgb_q    <= 12'h000;
      end else begin
         rgb_q  <= rgb_d;
         miss_q <= 1'b0;
         if (frame_tick) begin
            paddle_q <= paddle_d;
            unique case (state_q)
               IDLE: begin
                  ball_x_q <= park_x_d;
                  ball_y_q <= C_PARKY;
                  if (serve) begin
                     state_q <= PLAY;
                     dx_q    <= C_VP;
                     dy_q    <= C_VN;
                  end
               end
               PLAY: begin
                  if (by >= C_SH) begin
                     miss_q   <= 1'b1;
                     ball_x_q <= park_x_d;
                     ball_y_q <= C_PARKY;
                     if (lives_q == 2'd1) begin
                        lives_q <= 2'd0;
                        state_q <= OVER;
                        over_q  <= 1'b1;
                     end else begin
                        lives_q <= lives_q - 2'd1;
                        state_q <= IDLE;
                     end
                  end else begin
                     dx_q     <= dx_d;
                     dy_q     <= dy_d;
                     ball_x_q <= ball_x_d;
                     ball_y_q <= ball_y_d;
                  end
               end
               OVER: begin
                  if (serve) begin
                     lives_q <= C_LIVES;
                     state_q <= IDLE;
                     over_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rgb       = rgb_q;
   assign miss      = miss_q;
   assign lives     = lives_q;
   assign game_over = over_q;

endmodule
